// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and
// sticky overflow/underflow error flags that software clears.
module fifo_param #(
  parameter int DATA_W    = 6,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              RESET_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_wr,
  input  logic              fifo_rd,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              err_full,
  output logic              err_empty
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_C    = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_THRESH[ADDR_W:0];

  // Illegal thresholds stop elaboration rather than producing odd flags.
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_param: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("fifo_param: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic              rd_ok;
  logic              wr_ok;

  // Status flags decode straight from the registered count.
  assign fifo_count   = count;
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A write into a full FIFO is allowed only when a read frees a slot on the
  // same edge; a read from empty never falls through to a same-edge write.
  assign rd_ok = fifo_rd && !fifo_empty;
  assign wr_ok = fifo_wr && (!fifo_full || rd_ok);

  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    count_nxt = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // define which entries are valid, and an unreset array maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      count <= count_nxt;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

  // Sticky errors: a new violation on the clearing edge takes priority.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      err_full  <= 1'b0;
      err_empty <= 1'b0;
    end else begin
      if (fifo_wr && fifo_full && !rd_ok) err_full <= 1'b1;
      else if (err_clr)                   err_full <= 1'b0;

      if (fifo_rd && fifo_empty)          err_empty <= 1'b1;
      else if (err_clr)                   err_empty <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: read data checked by a scoreboard monitor,
// status/count checked against hand-computed values after each edge.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       RESET_L;
  logic [5:0] data_in;
  logic       fifo_wr, fifo_rd, err_clr;
  logic [5:0] data_out;
  logic       fifo_empty, fifo_full, almost_full, almost_empty;
  logic [3:0] fifo_count;
  logic       err_full, err_empty;

  int vectors    = 0;
  int miscompares = 0;

  logic [5:0] exp_q[$];
  logic       rd_exp  = 1'b0;
  logic       rd_seen = 1'b0;

  fifo_param dut (
    .clk         (clk),
    .RESET_L     (RESET_L),
    .data_in     (data_in),
    .fifo_wr     (fifo_wr),
    .fifo_rd     (fifo_rd),
    .err_clr     (err_clr),
    .data_out    (data_out),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .fifo_count  (fifo_count),
    .err_full    (err_full),
    .err_empty   (err_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: an edge that accepted a read presents data_out afterwards.
  always @(posedge clk) rd_seen <= rd_exp;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_underrun: read seen with empty scoreboard (t=%0t)", $time);
      end else begin
        check("sb_data_out", {26'd0, data_out}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  // One clock of stimulus; a read expected to be accepted queues its data.
  task automatic cyc(input bit wr, input bit rd, input logic [5:0] din,
                     input bit clr, input bit exp_rd, input logic [5:0] exp_d);
    fifo_wr = wr;
    fifo_rd = rd;
    data_in = din;
    err_clr = clr;
    rd_exp  = exp_rd;
    if (exp_rd) exp_q.push_back(exp_d);
    @(posedge clk);
    #1;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    err_clr = 1'b0;
    rd_exp  = 1'b0;
    data_in = '0;
  endtask

  task automatic check_status(input string tag, input int cnt, input bit ef, input bit ee);
    check({tag, "_count"}, fifo_count, cnt);
    check({tag, "_empty"}, fifo_empty, cnt == 0);
    check({tag, "_full"}, fifo_full, cnt == 8);
    check({tag, "_af"}, almost_full, cnt >= 6);
    check({tag, "_ae"}, almost_empty, cnt <= 2);
    check({tag, "_err_full"}, err_full, ef);
    check({tag, "_err_empty"}, err_empty, ee);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_L = 1'b0;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    err_clr = 1'b0;
    data_in = '0;
    #12;
    check_status("reset", 0, 1'b0, 1'b0);
    check("reset_data_out", data_out, 6'h00);
    @(negedge clk);
    RESET_L = 1'b1;
    @(posedge clk);
    #1;

    // 1: single write then read
    cyc(1, 0, 6'b010010, 0, 0, 6'h00);
    check_status("t1_wr", 1, 1'b0, 1'b0);
    cyc(0, 1, 6'h00, 0, 1, 6'b010010);
    check_status("t1_rd", 0, 1'b0, 1'b0);

    // 2: fill to full, then overflow
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 6'(i), 0, 0, 6'h00);
      check_status($sformatf("t2_fill%0d", i), i, 1'b0, 1'b0);
    end
    cyc(1, 0, 6'h3F, 0, 0, 6'h00);
    check_status("t2_ovf", 8, 1'b1, 1'b0);

    // 5: clear, then clear coinciding with a fresh overflow
    cyc(0, 0, 6'h00, 1, 0, 6'h00);
    check_status("t5_clr", 8, 1'b0, 1'b0);
    cyc(1, 0, 6'h3F, 1, 0, 6'h00);
    check_status("t5_clr_ovf", 8, 1'b1, 1'b0);
    cyc(0, 0, 6'h00, 1, 0, 6'h00);
    check_status("t5_clr2", 8, 1'b0, 1'b0);

    // 2 (cont.): drain; 3F must never appear
    for (int i = 1; i <= 8; i++) cyc(0, 1, 6'h00, 0, 1, 6'(i));
    check_status("t2_drained", 0, 1'b0, 1'b0);

    // 3: simultaneous read/write at full, wrapping pointers
    for (int i = 0; i < 8; i++) cyc(1, 0, 6'h11 + 6'(i), 0, 0, 6'h00);
    check_status("t3_full", 8, 1'b0, 1'b0);
    cyc(1, 1, 6'h2A, 0, 1, 6'h11);
    check_status("t3_rdwr", 8, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) cyc(0, 1, 6'h00, 0, 1, 6'h11 + 6'(i));
    cyc(0, 1, 6'h00, 0, 1, 6'h2A);
    check_status("t3_drained", 0, 1'b0, 1'b0);

    // 4: simultaneous read/write at empty
    cyc(1, 1, 6'h15, 0, 0, 6'h00);
    check_status("t4_rdwr", 1, 1'b0, 1'b1);
    check("t4_data_hold", data_out, 6'h2A);
    cyc(0, 1, 6'h00, 0, 1, 6'h15);
    check_status("t4_rd", 0, 1'b0, 1'b1);
    cyc(0, 0, 6'h00, 1, 0, 6'h00);
    check_status("t4_clr", 0, 1'b0, 1'b0);

    // 6: asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) cyc(1, 0, 6'h21 + 6'(i), 0, 0, 6'h00);
    check_status("t6_fill", 5, 1'b0, 1'b0);
    #2;
    RESET_L = 1'b0;
    #1;
    check_status("t6_in_reset", 0, 1'b0, 1'b0);
    check("t6_reset_data", data_out, 6'h00);
    #2;
    RESET_L = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 1, 6'h00, 0, 0, 6'h00);
    check_status("t6_rd_after", 0, 1'b0, 1'b1);
    check("t6_data_after", data_out, 6'h00);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
